// File: rtl/reg_file_sb.sv
// Parametrised register file with NUM_READ registered read ports, one write port,
// write-first bypass, optional hardwired-zero r0 and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 8,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read,
  input  logic [NUM_READ*AW-1:0]        rs_addr,
  output logic [NUM_READ*REG_WIDTH-1:0] rs_out,
  output logic [NUM_READ-1:0]           rs_busy,
  input  logic                          write,
  input  logic [AW-1:0]                 rd_addr,
  input  logic [REG_WIDTH-1:0]          rd_in,
  input  logic                          claim,
  input  logic [AW-1:0]                 claim_addr,
  output logic [NUM_REGS-1:0]           busy_vec
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NUM_REGS);

  logic [REG_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic [NUM_READ*REG_WIDTH-1:0] rs_out_q, rs_out_d;
  logic [NUM_READ-1:0]           rs_busy_q, rs_busy_d;
  logic                          wr_legal, cl_legal;

  // A legal target is also exactly the set of addresses that read real storage.
  function automatic logic is_target(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_legal = write && is_target(rd_addr);
  assign cl_legal = claim && is_target(claim_addr);

  // Claim is applied after the writeback clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_legal && (rd_addr == AW'(k)))    busy_d[k] = 1'b0;
      if (cl_legal && (claim_addr == AW'(k))) busy_d[k] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]        addr;
    logic                 valid, hit, cur_busy;
    logic [REG_WIDTH-1:0] cur_val;

    assign addr  = rs_addr[i*AW +: AW];
    assign valid = is_target(addr);
    assign hit   = wr_legal && (rd_addr == addr);

    // Compare-based lookup so an out-of-range address never indexes the array.
    always_comb begin
      cur_val  = '0;
      cur_busy = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (addr == AW'(k)) begin
          cur_val  = regs_q[k];
          cur_busy = busy_q[k];
        end
      end
    end

    assign rs_out_d[i*REG_WIDTH +: REG_WIDTH] = !valid ? '0 : (hit ? rd_in : cur_val);
    assign rs_busy_d[i] = valid && cur_busy && !hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      busy_q    <= '0;
      rs_out_q  <= '0;
      rs_busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_legal && (rd_addr == AW'(k))) regs_q[k] <= rd_in;
      end
      if (read) begin
        rs_out_q  <= rs_out_d;
        rs_busy_q <= rs_busy_d;
      end
    end
  end

  assign rs_out   = rs_out_q;
  assign rs_busy  = rs_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the team's 8-bit register file, with per-register busy bits.
- NUM_READ registered read ports, one write port, write-first bypass, optional hardwired-zero register 0.
- Per-register busy (scoreboard) bits: issue logic marks a destination pending with a claim; writeback clears the bit.
- Sits between decode/issue and writeback in the emulator datapath; drives operand values plus per-operand busy flags for stall logic.

Parameters:
NUM_REGS, 16, number of architectural registers (>=2)
REG_WIDTH, 8, data width in bits
NUM_READ, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and claims; 0 = register 0 is ordinary
AW (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
read  in  1  read enable for all ports
rs_addr  in  NUM_READ*AW  packed read addresses; port i = bits [i*AW +: AW]
rs_out  out  NUM_READ*REG_WIDTH  packed registered read data; port i = bits [i*REG_WIDTH +: REG_WIDTH]
rs_busy  out  NUM_READ  registered busy flag per read port
write  in  1  write enable
rd_addr  in  AW  write address
rd_in  in  REG_WIDTH  write data
claim  in  1  mark a register pending
claim_addr  in  AW  register to mark pending
busy_vec  out  NUM_REGS  current scoreboard, bit k = register k pending

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - all registers = 0; rs_out = 0; rs_busy = 0; busy_vec = 0.
  - Takes effect immediately, not at the next edge.
  - First edge after deassertion behaves normally.
- Address validity:
  - An address is valid iff it is < NUM_REGS.
  - With ZERO_REG=1, address 0 is valid for reads but is not a write or claim target.
- Write: at posedge, if write and rd_addr is a legal target, regs[rd_addr] <= rd_in. Otherwise no state change.
- Read, 1-cycle latency: at posedge, if read, for each port i:
  - rs_out[i] <= 0 if rs_addr[i] is out of range, or if ZERO_REG=1 and rs_addr[i]==0.
  - else rs_out[i] <= rd_in if write and rd_addr==rs_addr[i] and the write is legal (write-first bypass).
  - else rs_out[i] <= regs[rs_addr[i]].
  - If read=0, rs_out and rs_busy hold their previous values.
  - Ports are independent. Any number of ports may read the same address.
- Scoreboard update at posedge:
  - busy[rd_addr] cleared by a legal write.
  - busy[claim_addr] set by claim to a legal target.
  - Claim and write to the same register in the same cycle: the claim wins, and busy ends 1 (a new producer is issued).
  - Claim to an already-busy register: stays 1.
  - Write to a non-busy register: stays 0, no error.
  - busy_vec is the registered scoreboard state.
- rs_busy at posedge when read=1:
  - rs_busy[i] <= busy[rs_addr[i]] AND NOT (legal write to rs_addr[i] this cycle).
  - The bypassed value is never flagged busy.
  - A same-cycle claim is NOT visible on rs_busy; it applies to later readers.
  - Out-of-range or zero-register reads give rs_busy=0.
- No X propagation: out-of-range addresses never index the array.
- Read and write in the same cycle to different registers: both take effect. No port priority is required beyond the bypass rule.

Test Plan:
- Reset mid-stream:
  - Stimulus: write 0xA5 to r3, then claim r5, then assert reset between edges.
  - Required: rs_out, rs_busy and busy_vec go to 0 immediately. Reading r3 after release returns 0x00.
- Basic read/write:
  - Stimulus: write r3=0x5A; next cycle read=1 with rs_addr port0=3, port1=3.
  - Required: one edge later both ports show 0x5A, rs_busy=2'b00.
- Bypass:
  - Stimulus: same cycle write r7=0x3C, read port0=7, port1=2 (r2 holds 0x11).
  - Required: after one edge port0=0x3C, port1=0x11.
- Zero register (ZERO_REG=1):
  - Stimulus: write r0=0xFF with claim r0, then read r0.
  - Required: rs_out=0x00, rs_busy=0, busy_vec[0]=0.
- Scoreboard:
  - Stimulus: claim r4; next cycle read r4; then write r4=0x77 with read r4 in the same cycle.
  - Required: first read gives rs_busy[0]=1 and busy_vec[4]=1. Second read gives 0x77 with rs_busy[0]=0 and busy_vec[4]=0.
- Simultaneous claim and write:
  - Stimulus: claim r9 and write r9=0x12 in the same cycle; r9 previously busy.
  - Required: busy_vec[9]=1 afterwards. A following read returns 0x12 with rs_busy=1.
  - Also: read with read=0 leaves rs_out unchanged. Out-of-range address 15 with NUM_REGS=12 returns 0.
